// File: rtl/servo_motion_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo motion sequencer:
//   - controller state encoding (IDLE / MOVE / SETTLE)
//   - joint count, the "home all joints" command code, default home position
//   - helpers for clamping a requested position and ramping one joint
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int         NUM_JOINTS   = 3;
  localparam logic [1:0] JOINT_ALL    = 2'd3;
  localparam logic [7:0] HOME_DEFAULT = 8'd128;

  typedef logic [7:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Limit a requested position to the legal window [lo, hi].
  function automatic pos_t clamp_pos(input pos_t req, input pos_t lo, input pos_t hi);
    if (req < lo) return lo;
    if (req > hi) return hi;
    return req;
  endfunction

  // One frame of motion for a single joint: move by at most 'step' toward
  // 'tgt'. The difference is taken as 9-bit signed so both directions are
  // exact; when the remaining distance is within one step the joint lands
  // exactly on target, so it can never overshoot or wrap.
  function automatic pos_t step_toward(input pos_t cur, input pos_t tgt, input pos_t step);
    logic signed [8:0] diff;
    logic signed [8:0] step_s;
    diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step_s = $signed({1'b0, step});
    if (diff > step_s)  return cur + step;
    if (diff < -step_s) return cur - step;
    return tgt;
  endfunction

endpackage

// File: rtl/servo_motion_sequencer_if.sv
// -----------------------------------------------------------------------------
// servo_motion_sequencer_if
// Command handshake into the servo motion sequencer.
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : sequencer can accept a command (slave -> master)
//   cmd_joint  : target joint 0..2, JOINT_ALL = home every joint
//   cmd_pos    : requested position (ignored for JOINT_ALL)
// A command transfers on a clock edge where cmd_valid and cmd_ready are high.
// -----------------------------------------------------------------------------
interface servo_motion_sequencer_if;
  import servo_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_joint;
  pos_t       cmd_pos;

  modport master (output cmd_valid, output cmd_joint, output cmd_pos, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_joint, input  cmd_pos, output cmd_ready);
endinterface

// File: rtl/servo_motion_sequencer_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Free-running servo frame divider. Counts 0..FRAME_DIV-1 and raises 'tick'
// for the single cycle in which the count is FRAME_DIV-1. Only reset
// restarts the count; command traffic never does.
//   clk  : system clock
//   rst  : synchronous active-high reset (count returns to 0)
//   tick : one-cycle frame strobe
// -----------------------------------------------------------------------------
module frame_tick_gen #(
  parameter int FRAME_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, matching real flip-flops.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + CW'(1);
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_motion_sequencer.sv
// -----------------------------------------------------------------------------
// servo_motion_sequencer
// Accepts one joint-position command at a time and ramps the three servo
// position registers toward their targets by at most STEP per servo frame,
// then holds for SETTLE_FRAMES frames before signalling completion.
//   clk, rst    : clock and synchronous active-high reset
//   cmd         : command handshake (slave side), see servo_motion_sequencer_if
//   pos0..pos2  : registered joint positions, one per servo PWM channel
//   busy        : high while moving or settling
//   done        : one-cycle pulse, the cycle the controller returns to IDLE
//   cmd_err     : one-cycle pulse the cycle after an accepted command whose
//                 position had to be clamped (the clamped move still runs)
// -----------------------------------------------------------------------------
module servo_motion_sequencer
  import servo_pkg::*;
#(
  parameter int FRAME_DIV     = 1000000,
  parameter int STEP          = 2,
  parameter int POS_MIN       = 0,
  parameter int POS_MAX       = 255,
  parameter int HOME          = int'(HOME_DEFAULT),
  parameter int SETTLE_FRAMES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  servo_motion_sequencer_if.slave  cmd,
  output pos_t                     pos0,
  output pos_t                     pos1,
  output pos_t                     pos2,
  output logic                     busy,
  output logic                     done,
  output logic                     cmd_err
);

  localparam pos_t STEP_P = pos_t'(STEP);
  localparam pos_t POS_LO = pos_t'(POS_MIN);
  localparam pos_t POS_HI = pos_t'(POS_MAX);
  localparam pos_t HOME_P = pos_t'(HOME);

  // A zero settle time is treated as a single frame so the counter compare
  // stays well formed.
  localparam int               SETTLE_N = (SETTLE_FRAMES < 1) ? 1 : SETTLE_FRAMES;
  localparam int               SC_W     = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE_N - 1);

  state_t          state_q, state_d;
  pos_t            pos_q    [NUM_JOINTS];
  pos_t            target_q [NUM_JOINTS];
  pos_t            pos_step [NUM_JOINTS];
  logic [SC_W-1:0] settle_q;
  logic            frame_tick;
  logic            accept;
  logic            all_arrive;
  pos_t            req_clamped;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_frame_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (frame_tick)
  );

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign accept        = cmd.cmd_valid && (state_q == ST_IDLE) && !rst;
  assign req_clamped   = clamp_pos(cmd.cmd_pos, POS_LO, POS_HI);
  assign busy          = (state_q == ST_MOVE) || (state_q == ST_SETTLE);

  // Next position of every joint if this cycle is a frame tick, and whether
  // that update leaves every joint on target (decides MOVE -> SETTLE, which
  // also covers a command that was already at target).
  // NOTE: every combinational output gets a default before any branch; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    all_arrive = 1'b1;
    for (int j = 0; j < NUM_JOINTS; j++) begin
      pos_step[j] = step_toward(pos_q[j], target_q[j], STEP_P);
      if (pos_step[j] != target_q[j]) all_arrive = 1'b0;
    end
  end

  // Controller next state. done is decoded here so that it is high in the
  // same cycle the state leaves SETTLE; a held command is then taken on the
  // following cycle, once cmd_ready is back.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_MOVE;
      ST_MOVE:   if (frame_tick && all_arrive) state_d = ST_SETTLE;
      ST_SETTLE: if (frame_tick && settle_q == SC_LAST) begin
                   state_d = ST_IDLE;
                   done    = !rst;
                 end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Positions, targets, settle counter and the clamp flag. Reset snaps every
  // joint home immediately, which also aborts any motion in progress.
  // NOTE: the position/target arrays are reset element by element; they are
  // a handful of flops driving outputs, not a RAM, so a reset value is cheap
  // and required.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_JOINTS; j++) begin
        pos_q[j]    <= HOME_P;
        target_q[j] <= HOME_P;
      end
      settle_q <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= accept && (cmd.cmd_joint != JOINT_ALL) && (req_clamped != cmd.cmd_pos);

      if (accept) begin
        for (int j = 0; j < NUM_JOINTS; j++) begin
          if (cmd.cmd_joint == JOINT_ALL)   target_q[j] <= HOME_P;
          else if (cmd.cmd_joint == 2'(j))  target_q[j] <= req_clamped;
        end
      end

      if (state_q == ST_MOVE && frame_tick) begin
        for (int j = 0; j < NUM_JOINTS; j++) pos_q[j] <= pos_step[j];
      end

      if (state_q != ST_SETTLE) settle_q <= '0;
      else if (frame_tick)      settle_q <= settle_q + SC_W'(1);
    end
  end

  assign pos0 = pos_q[0];
  assign pos1 = pos_q[1];
  assign pos2 = pos_q[2];

endmodule
